// File: rtl/shared_reg_arbiter.sv
// Round-robin owner of one shared resettable register: each write runs IDLE -> GRANT -> DONE,
// and a clear request takes priority through IDLE -> CLEAR.
module shared_reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic                   clr,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic                   clr_done,
  output logic [WIDTH-1:0]       q,
  output logic                   busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_q, win_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             clr_done_q, clr_done_d;

  logic [WIDTH-1:0] wdata_arr [N_REQ];
  logic [PTR_W-1:0] rot_idx [N_REQ];
  logic [N_REQ-1:0] win_onehot;
  logic [N_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;
  logic [PTR_W-1:0] win_inc;
  logic             req_win;

  // rot_idx[k] is the requester examined k-th in the scan starting at ptr.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
      logic [PTR_W:0] sum;
      assign wdata_arr[gi]   = wdata[gi*WIDTH +: WIDTH];
      assign sum             = {1'b0, ptr_q} + (PTR_W+1)'(gi);
      assign rot_idx[gi]     = (sum >= (PTR_W+1)'(N_REQ)) ? PTR_W'(sum - (PTR_W+1)'(N_REQ))
                                                          : PTR_W'(sum);
      assign win_onehot[gi]  = (win_q == PTR_W'(gi));
      assign pick_onehot[gi] = (pick_idx == PTR_W'(gi));
    end
  endgenerate

  // Scan from the far end so the lowest rotated position is the final winner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[rot_idx[k]]) begin
        pick_valid = 1'b1;
        pick_idx   = rot_idx[k];
      end
    end
  end

  assign win_inc = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
  assign req_win = |(req & win_onehot);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    data_d     = data_q;
    grant_d    = '0;
    ack_d      = '0;
    clr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
        end else if (pick_valid) begin
          win_d   = pick_idx;
          grant_d = pick_onehot;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A dropped request abandons the write without touching q or ptr.
        if (req_win) begin
          data_d  = wdata_arr[win_q];
          ptr_d   = win_inc;
          ack_d   = win_onehot;
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        data_d     = '0;
        clr_done_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      data_q     <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      data_q     <= data_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign clr_done = clr_done_q;
  assign q        = data_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin controller that shares a single resettable storage register among `N_REQ` requesters and sequences each write through a fixed grant/commit handshake. A separate clear path is also sequenced through the same state machine. It sits in front of the resettable flop banks produced by synthesis, so only one agent ever drives the register's D input in a given cycle.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 8: width of the shared register.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester write request; level signal, held until `ack`.
- `wdata`  in  N_REQ*WIDTH  requester i's data in bits [i*WIDTH +: WIDTH].
- `clr`  in  1  request to clear the register to 0; level signal, held until `clr_done`.
- `grant`  out  N_REQ  one-hot; winner during GRANT.
- `ack`  out  N_REQ  one-hot 1-cycle pulse in DONE for the committed requester.
- `clr_done`  out  1  1-cycle pulse after a clear commits.
- `q`  out  WIDTH  shared register contents.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Reset state:
  - state = IDLE, `q` = 0, `grant` = 0, `ack` = 0, `clr_done` = 0, `busy` = 0.
  - Priority pointer `ptr` = 0, so requester 0 has highest priority.
- States: IDLE, GRANT, DONE, CLEAR.
- IDLE:
  - If `clr` = 1, go to CLEAR. `clr` beats all `req` bits.
  - Else if any `req` bit is set, pick the winner: the first set bit scanning `ptr`, `ptr+1`, … modulo `N_REQ`. Register it as `win` and go to GRANT.
  - Else stay in IDLE.
- GRANT:
  - `grant[win]` = 1.
  - If `req[win]` is still 1 at the edge, then `q` ← `wdata[win]`, `ptr` ← (`win`+1) mod `N_REQ`, and go to DONE.
  - If `req[win]` dropped, abort: `q` and `ptr` are unchanged, go to IDLE, and no `ack` is issued.
- DONE:
  - `ack[win]` = 1 and `grant` = 0. Always returns to IDLE on the next edge.
- CLEAR:
  - `q` ← 0 at the edge, then go to IDLE.
  - `clr_done` is a registered pulse that is high for the cycle after CLEAR (the IDLE cycle).
- `clr` or `req` changes while in GRANT, DONE or CLEAR are ignored until IDLE resamples them.
- A requester still holding `req` in the IDLE cycle after its own `ack` is eligible again. Because `ptr` has moved past it, any other pending requester wins first.
- `q` changes only at the end of a committed GRANT, at the end of CLEAR, or on reset.
- `reset` asserted in any state wins over every transition:
  - The next cycle is IDLE with reset values.
  - Any in-flight write is discarded, and no `ack` or `clr_done` is issued.

## Timing
- Write latency: `req` sampled high at edge E0 puts GRANT in cycle 1.
  - The new `q` is visible in cycle 2 (DONE), which is also the cycle `ack` is high.
- Throughput: one write per 3 cycles (IDLE, GRANT, DONE).
- Clear latency: `clr` sampled at E0 puts CLEAR in cycle 1.
  - `q` = 0 is visible in cycle 2, the same cycle `clr_done` is high.
- `grant`, `ack` and `clr_done` are registered outputs: no combinational path from inputs to outputs.
- `busy` is 0 only in IDLE.

## Test plan
- Reset then idle:
  - `reset`=1 for 2 cycles with `req`=4'b1111 → `q`=0, `grant`=0, `busy`=0 throughout.
  - After release, requester 0 is granted first.
- Single write:
  - `req`=4'b0100, `wdata[2]`=8'hA5 → `grant`=4'b0100 in cycle 1.
  - `q`=8'hA5 and `ack`=4'b0100 in cycle 2; IDLE in cycle 3.
- Round-robin fairness:
  - `req`=4'b1111 held with `wdata` values 8'h10/11/12/13 → `ack` sequence is 0,1,2,3,0 at 3-cycle spacing.
  - `q` follows 8'h10, 11, 12, 13, 10.
- Clear priority:
  - `q`=8'hA5; then `clr`=1 together with `req`=4'b0001 in IDLE → CLEAR first, `q`=0 and `clr_done`=1 in cycle 2.
  - Requester 0 then completes GRANT/DONE, ending with `q`=`wdata[0]`.
- Abort:
  - `req[1]` drops during GRANT → no `ack`, `q` unchanged, `ptr` unchanged.
  - Re-asserting `req[1]` alone grants requester 1 again.
- Reset mid-operation:
  - `reset` asserted during GRANT with `req[3]`=1 and `wdata[3]`=8'hFF → `q`=0 next cycle, no `ack`, `ptr`=0.
